// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the ALU arbiter.
// The master side belongs to the requesters and the slave side to the arbiter.
// Requester i owns bit i of every 2-bit field and slice i of the packed operand/opcode fields.
interface alu_arbiter_if #(
    parameter int N = 16
);
    logic [1:0]     reqValid;
    logic [1:0]     reqReady;
    logic [5:0]     reqOp;
    logic [2*N-1:0] reqA;
    logic [2*N-1:0] reqB;
    logic [1:0]     rspValid;
    logic [1:0]     rspReady;
    logic [N-1:0]   rspResult;
    logic           rspCarry;

    modport master (
        output reqValid, reqOp, reqA, reqB, rspReady,
        input  reqReady, rspValid, rspResult, rspCarry
    );

    modport slave (
        input  reqValid, reqOp, reqA, reqB, rspReady,
        output reqReady, rspValid, rspResult, rspCarry
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Only one operation is in flight at a time: IDLE accepts it, EXEC drives the ALU
// for one cycle, and RESP holds the result until its owner consumes it.
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 wins every tie and no
// lastGrant state exists; without it ties alternate round-robin.
module alu_arbiter #(
    parameter int N = 16
) (
    input  logic            clk,
    input  logic            rstN,
    alu_arbiter_if.slave    bus,
    output logic [2:0]      aluOpcode,
    output logic [N-1:0]    aluA,
    output logic [N-1:0]    aluB,
    input  logic [N-1:0]    aluS,
    input  logic            aluCout,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } stateT;

    stateT          state;
    stateT          nextState;
    logic [2:0]     opReg;
    logic [N-1:0]   aReg;
    logic [N-1:0]   bReg;
    logic [N-1:0]   resultReg;
    logic           carryReg;
    logic           owner;
    logic           grantIdx;
    logic           handshake;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           lastGrant;
`endif

    // Choose which requester is offered reqReady this cycle
    always_comb begin
        grantIdx = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        grantIdx = ~bus.reqValid[0];
`else
        if (bus.reqValid == 2'b11) begin
            grantIdx = ~lastGrant;
        end else begin
            grantIdx = bus.reqValid[1];
        end
`endif
    end

    // Next-state decode plus the handshake and response outputs
    always_comb begin
        nextState    = state;
        bus.reqReady = 2'b00;
        bus.rspValid = 2'b00;
        busy         = (state != IDLE);
        if (rstN && (state == IDLE) && (bus.reqValid != 2'b00)) begin
            bus.reqReady = grantIdx ? 2'b10 : 2'b01;
        end
        if (state == RESP) begin
            bus.rspValid = owner ? 2'b10 : 2'b01;
        end
        case (state)
            IDLE:    if (handshake) nextState = EXEC;
            EXEC:    nextState = RESP;
            RESP:    if (bus.rspReady[owner]) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign handshake     = |(bus.reqValid & bus.reqReady);
    assign aluOpcode     = opReg;
    assign aluA          = aReg;
    assign aluB          = bReg;
    assign bus.rspResult = resultReg;
    assign bus.rspCarry  = carryReg;

    // State register; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Latch the granted requester's opcode, operands and index on acceptance
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            opReg <= 3'd0;
            aReg  <= '0;
            bReg  <= '0;
            owner <= 1'b0;
        end else if (handshake) begin
            opReg <= grantIdx ? bus.reqOp[5:3] : bus.reqOp[2:0];
            aReg  <= grantIdx ? bus.reqA[2*N-1:N] : bus.reqA[N-1:0];
            bReg  <= grantIdx ? bus.reqB[2*N-1:N] : bus.reqB[N-1:0];
            owner <= grantIdx;
        end
    end

    // Capture the ALU output at the end of the single EXEC cycle
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            resultReg <= '0;
            carryReg  <= 1'b0;
        end else if (state == EXEC) begin
            resultReg <= aluS;
            carryReg  <= aluCout;
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Remember the last winner; resets to 1 so requester 0 takes the first tie
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lastGrant <= 1'b1;
        end else if (handshake) begin
            lastGrant <= grantIdx;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. The bench supplies the shared ALU itself
// (add, sub, and, or, xor, shl, shr, inc) and keeps a scoreboard of expected
// responses pushed at each accepted request and popped when a response appears.
module tb_alu_arbiter;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           rstN;
    logic [2:0]     aluOpcode;
    logic [N-1:0]   aluA;
    logic [N-1:0]   aluB;
    logic [N-1:0]   aluS;
    logic           aluCout;
    logic           busy;

    int assertCount = 0;
    int failCount   = 0;
    int cycle       = 0;

    typedef struct {
        logic [1:0]   owner;
        logic [N-1:0] result;
        logic         carry;
        int           hsCycle;
    } expEntryT;

    expEntryT     sbQ[$];
    int           grantLog[$];
    expEntryT     pushed;
    expEntryT     popped;
    logic         rspSeen = 1'b0;
    logic [1:0]   lastObsValid;
    logic [N-1:0] lastObsResult;
    logic         lastObsCarry;
    logic         sel;
    logic [2:0]   opSel;
    logic [N-1:0] aSel;
    logic [N-1:0] bSel;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .bus       (bus),
        .aluOpcode (aluOpcode),
        .aluA      (aluA),
        .aluB      (aluB),
        .aluS      (aluS),
        .aluCout   (aluCout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, result}
    function automatic logic [N:0] aluEval(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} + {1'b0, ~b} + 17'd1;
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {a, 1'b0};
            3'd6:    return {a[0], 1'b0, a[N-1:1]};
            default: return {1'b0, a} + 17'd1;
        endcase
    endfunction

    // The shared combinational ALU seen by the DUT
    always_comb {aluCout, aluS} = aluEval(aluOpcode, aluA, aluB);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [5:0] ops,
                                 input logic [2*N-1:0] a, input logic [2*N-1:0] b);
        tick();
        bus.reqOp    = ops;
        bus.reqA     = a;
        bus.reqB     = b;
        bus.reqValid = valid;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 12 && !done; i++) begin
            tick();
            if (!busy && sbQ.size() == 0) done = 1'b1;
        end
        if (!done) checkOutput("drainTimeout", 32'd0, 32'd1);
    endtask

    task automatic resetDut();
        tick();
        rstN = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    // One request from a single requester; the other slot carries random noise
    task automatic runSingle(input int idx, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [5:0]     ops;
        logic [2*N-1:0] aa;
        logic [2*N-1:0] bb;
        bit             hit;
        ops = {3'($urandom), 3'($urandom)};
        aa  = {16'($urandom), 16'($urandom)};
        bb  = {16'($urandom), 16'($urandom)};
        if (idx == 1) begin
            ops[5:3] = op; aa[2*N-1:N] = a; bb[2*N-1:N] = b;
        end else begin
            ops[2:0] = op; aa[N-1:0] = a; bb[N-1:0] = b;
        end
        applyStimulus((idx == 1) ? 2'b10 : 2'b01, ops, aa, bb);
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if ((bus.reqValid & bus.reqReady) != 2'b00) begin
                hit = 1'b1;
                checkOutput("grant", 32'(bus.reqReady), (idx == 1) ? 32'd2 : 32'd1);
            end
        end
        if (!hit) checkOutput("hsTimeout", 32'd0, 32'd1);
        tick();
        bus.reqValid = 2'b00;
        waitDrain();
    endtask

    // Monitor: push expectations on handshakes, pop and compare on new responses
    always @(negedge clk) begin
        cycle++;
        if (!rstN) begin
            sbQ.delete();
            rspSeen = 1'b0;
        end else begin
            if (bus.rspValid != 2'b00 && !rspSeen) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedRsp", 32'(bus.rspValid), 32'd0);
                end else begin
                    popped = sbQ.pop_front();
                    lastObsValid  = bus.rspValid;
                    lastObsResult = bus.rspResult;
                    lastObsCarry  = bus.rspCarry;
                    checkOutput("rspValid", 32'(bus.rspValid), 32'(popped.owner));
                    checkOutput("rspResult", 32'(bus.rspResult), 32'(popped.result));
                    checkOutput("rspCarry", 32'(bus.rspCarry), 32'(popped.carry));
                    checkOutput("latency", 32'(cycle - popped.hsCycle), 32'd2);
                end
                rspSeen = 1'b1;
            end
            if ((bus.rspValid & bus.rspReady) != 2'b00) rspSeen = 1'b0;
            if ((bus.reqValid & bus.reqReady) != 2'b00) begin
                sel   = bus.reqReady[1];
                opSel = sel ? bus.reqOp[5:3] : bus.reqOp[2:0];
                aSel  = sel ? bus.reqA[2*N-1:N] : bus.reqA[N-1:0];
                bSel  = sel ? bus.reqB[2*N-1:N] : bus.reqB[N-1:0];
                pushed.owner   = sel ? 2'b10 : 2'b01;
                {pushed.carry, pushed.result} = aluEval(opSel, aSel, bSel);
                pushed.hsCycle = cycle;
                sbQ.push_back(pushed);
                grantLog.push_back(sel ? 1 : 0);
            end
        end
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int expGrant[4];
        bit hit;
        logic [N:0] expRes;
`ifdef ALU_ARB_FIXED_PRIO_EN
        expGrant = '{0, 0, 0, 0};
`else
        expGrant = '{0, 1, 0, 1};
`endif
        rstN         = 1'b0;
        bus.reqValid = 2'b00;
        bus.reqOp    = '0;
        bus.reqA     = '0;
        bus.reqB     = '0;
        bus.rspReady = 2'b11;

        // Reset state, including reqReady held low while both request
        #3;
        bus.reqValid = 2'b11;
        #1;
        checkOutput("rstReqReady", 32'(bus.reqReady), 32'd0);
        checkOutput("rstRspValid", 32'(bus.rspValid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstResult", 32'(bus.rspResult), 32'd0);
        checkOutput("rstCarry", 32'(bus.rspCarry), 32'd0);
        checkOutput("rstOpcode", 32'(aluOpcode), 32'd0);
        checkOutput("rstAluA", 32'(aluA), 32'd0);
        checkOutput("rstAluB", 32'(aluB), 32'd0);
        bus.reqValid = 2'b00;
        tick();
        rstN = 1'b1;

        // Single request with 16-bit wrap into the sign bit
        runSingle(0, 3'd0, 16'd32767, 16'd5);
        checkOutput("singleResult", 32'(lastObsResult), 32'h8004);
        checkOutput("singleCarry", 32'(lastObsCarry), 32'd0);
        checkOutput("singleValid", 32'(lastObsValid), 32'd1);

        // Carry-out from requester 1
        runSingle(1, 3'd0, 16'hFFFF, 16'd1);
        checkOutput("carryResult", 32'(lastObsResult), 32'h0000);
        checkOutput("carryCarry", 32'(lastObsCarry), 32'd1);
        checkOutput("carryValid", 32'(lastObsValid), 32'd2);

        // Both requesters valid continuously after a fresh reset
        resetDut();
        grantLog.delete();
        applyStimulus(2'b11, {3'd1, 3'd0}, {16'd100, 16'd10}, {16'd1, 16'd20});
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (grantLog.size() >= 4) hit = 1'b1;
        end
        bus.reqValid = 2'b00;
        waitDrain();
        checkOutput("grantCount", 32'(grantLog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < grantLog.size()) checkOutput($sformatf("grant%0d", i), 32'(grantLog[i]), 32'(expGrant[i]));
        end

        // Backpressure: owner 0 stalls, non-owner ready bit must be ignored
        bus.rspReady = 2'b10;
        expRes = aluEval(3'd0, 16'hF000, 16'h2345);
        applyStimulus(2'b11, {3'd4, 3'd0}, {16'h5555, 16'hF000}, {16'h00FF, 16'h2345});
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            tick();
            if (bus.rspValid != 2'b00) hit = 1'b1;
        end
        if (!hit) checkOutput("bpTimeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpRspValid", 32'(bus.rspValid), 32'd1);
            checkOutput("bpResult", 32'(bus.rspResult), 32'h1345);
            checkOutput("bpCarry", 32'(bus.rspCarry), 32'd1);
            checkOutput("bpExpModel", 32'(bus.rspResult), 32'(expRes[N-1:0]));
            checkOutput("bpReqReady", 32'(bus.reqReady), 32'd0);
            checkOutput("bpBusy", 32'(busy), 32'd1);
            tick();
        end
        bus.reqValid = 2'b00;
        bus.rspReady = 2'b11;
        waitDrain();

        // Reset while in EXEC: discard the operation, next tie goes to requester 0
        applyStimulus(2'b01, {3'd0, 3'd2}, {16'd0, 16'h1234}, {16'd0, 16'h00FF});
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if ((bus.reqValid & bus.reqReady) != 2'b00) hit = 1'b1;
        end
        if (!hit) checkOutput("midHsTimeout", 32'd0, 32'd1);
        tick();
        checkOutput("midBusyBefore", 32'(busy), 32'd1);
        bus.reqValid = 2'b11;
        rstN = 1'b0;
        #1;
        checkOutput("midReqReady", 32'(bus.reqReady), 32'd0);
        checkOutput("midRspValid", 32'(bus.rspValid), 32'd0);
        checkOutput("midBusy", 32'(busy), 32'd0);
        checkOutput("midResult", 32'(bus.rspResult), 32'd0);
        checkOutput("midCarry", 32'(bus.rspCarry), 32'd0);
        checkOutput("midOpcode", 32'(aluOpcode), 32'd0);
        checkOutput("midAluA", 32'(aluA), 32'd0);
        checkOutput("midAluB", 32'(aluB), 32'd0);
        tick();
        tick();
        bus.reqValid = 2'b00;
        rstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("postRstRspValid", 32'(bus.rspValid), 32'd0);
            checkOutput("postRstBusy", 32'(busy), 32'd0);
        end
        grantLog.delete();
        applyStimulus(2'b11, {3'd3, 3'd4}, {16'h00F0, 16'h0F0F}, {16'h000F, 16'h00FF});
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if ((bus.reqValid & bus.reqReady) != 2'b00) hit = 1'b1;
        end
        if (!hit) checkOutput("postRstHsTimeout", 32'd0, 32'd1);
        tick();
        bus.reqValid = 2'b00;
        waitDrain();
        checkOutput("postRstGrantCount", 32'(grantLog.size()), 32'd1);
        if (grantLog.size() > 0) checkOutput("postRstGrant", 32'(grantLog[0]), 32'd0);

        // Sweep every opcode over small operands, alternating requesters
        begin
            int k;
            k = 0;
            for (int op = 0; op < 8; op++) begin
                for (int a = 0; a < 8; a++) begin
                    for (int b = 0; b < 8; b++) begin
                        runSingle(k % 2, 3'(op), 16'(a), 16'(b));
                        k++;
                    end
                end
            end
        end

        checkOutput("finalQueueEmpty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
